// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RISC-V core.
// Detects load-use hazards, squashes on flush/stall/empty D, and counts bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              ALUSrcAD,
    input  logic              ALUSrcBD,
    input  logic [2:0]        ALUControlD,
    input  logic [2:0]        Funct3D,
    input  logic              UsesRs1D,
    input  logic              UsesRs2D,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              FlushE,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic [2:0]        ALUControlE,
    output logic [2:0]        Funct3E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  BubbleCount
);

    localparam logic [1:0] RES_LOAD = 2'b01;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_lw_stall;
    logic w_squash;
    logic w_bubble;

    // Load in EX whose destination is read by the instruction in D; x0 never counts
    always_comb begin
        w_rs1_hit  = UsesRs1D && (Rs1D == RdE);
        w_rs2_hit  = UsesRs2D && (Rs2D == RdE);
        w_lw_stall = ValidE && (ResultSrcE == RES_LOAD) && (RdE != 5'd0)
                     && (w_rs1_hit || w_rs2_hit);
        w_squash   = FlushE || w_lw_stall;
        w_bubble   = w_squash || !ValidD;
    end

    assign StallF = w_lw_stall;
    assign StallD = w_lw_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E} <= '0;
            {Rs1E, Rs2E, RdE}                       <= '0;
            {RD1E, RD2E, ImmExtE, PCE, PCPlus4E}    <= '0;
        end else if (w_bubble) begin
            {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E} <= '0;
            {Rs1E, Rs2E, RdE}                       <= '0;
            {RD1E, RD2E, ImmExtE, PCE, PCPlus4E}    <= '0;
        end else begin
            {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E} <=
                {1'b1, RegWriteD, ResultSrcD, MemWriteD, BranchD, JumpD,
                 ALUSrcAD, ALUSrcBD, ALUControlD, Funct3D};
            {Rs1E, Rs2E, RdE}                    <= {Rs1D, Rs2D, RdD};
            {RD1E, RD2E, ImmExtE, PCE, PCPlus4E} <= {RD1D, RD2D, ImmExtD, PCD, PCPlus4D};
        end
    end

    // Empty-pipeline bubbles are not counted; the counter sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BubbleCount <= '0;
        end else if (w_squash && (BubbleCount != {CNT_W{1'b1}})) begin
            BubbleCount <= BubbleCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan cases plus random traffic
// compared against a transaction-level model of the EX slot and bubble counters.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        alusrca;
        logic        alusrcb;
        logic [2:0]  aluctl;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } stage_t;

    logic   clk = 1'b0;
    logic   reset;
    stage_t d;
    logic   uses1, uses2, flush;

    stage_t      e_obs, e_obs2;
    logic        stall_f, stall_d, stall_f2, stall_d2;
    logic [15:0] cnt_obs;
    logic [1:0]  cnt2_obs;

    stage_t      e_exp;
    int unsigned cnt_exp, cnt2_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ValidD(d.valid), .RegWriteD(d.regwrite),
        .ResultSrcD(d.resultsrc), .MemWriteD(d.memwrite), .BranchD(d.branch),
        .JumpD(d.jump), .ALUSrcAD(d.alusrca), .ALUSrcBD(d.alusrcb),
        .ALUControlD(d.aluctl), .Funct3D(d.funct3), .UsesRs1D(uses1), .UsesRs2D(uses2),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .RD1D(d.rd1), .RD2D(d.rd2),
        .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcp4), .FlushE(flush),
        .ValidE(e_obs.valid), .RegWriteE(e_obs.regwrite), .ResultSrcE(e_obs.resultsrc),
        .MemWriteE(e_obs.memwrite), .BranchE(e_obs.branch), .JumpE(e_obs.jump),
        .ALUSrcAE(e_obs.alusrca), .ALUSrcBE(e_obs.alusrcb), .ALUControlE(e_obs.aluctl),
        .Funct3E(e_obs.funct3), .Rs1E(e_obs.rs1), .Rs2E(e_obs.rs2), .RdE(e_obs.rd),
        .RD1E(e_obs.rd1), .RD2E(e_obs.rd2), .ImmExtE(e_obs.imm), .PCE(e_obs.pc),
        .PCPlus4E(e_obs.pcp4), .StallF(stall_f), .StallD(stall_d), .BubbleCount(cnt_obs)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .ValidD(d.valid), .RegWriteD(d.regwrite),
        .ResultSrcD(d.resultsrc), .MemWriteD(d.memwrite), .BranchD(d.branch),
        .JumpD(d.jump), .ALUSrcAD(d.alusrca), .ALUSrcBD(d.alusrcb),
        .ALUControlD(d.aluctl), .Funct3D(d.funct3), .UsesRs1D(uses1), .UsesRs2D(uses2),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .RD1D(d.rd1), .RD2D(d.rd2),
        .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcp4), .FlushE(flush),
        .ValidE(e_obs2.valid), .RegWriteE(e_obs2.regwrite), .ResultSrcE(e_obs2.resultsrc),
        .MemWriteE(e_obs2.memwrite), .BranchE(e_obs2.branch), .JumpE(e_obs2.jump),
        .ALUSrcAE(e_obs2.alusrca), .ALUSrcBE(e_obs2.alusrcb), .ALUControlE(e_obs2.aluctl),
        .Funct3E(e_obs2.funct3), .Rs1E(e_obs2.rs1), .Rs2E(e_obs2.rs2), .RdE(e_obs2.rd),
        .RD1E(e_obs2.rd1), .RD2E(e_obs2.rd2), .ImmExtE(e_obs2.imm), .PCE(e_obs2.pc),
        .PCPlus4E(e_obs2.pcp4), .StallF(stall_f2), .StallD(stall_d2), .BubbleCount(cnt2_obs)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A load sits in EX and the D instruction reads its (non-zero) destination
    function automatic logic model_stall();
        return e_exp.valid && e_exp.resultsrc == 2'b01 && e_exp.rd != 5'd0 &&
               ((uses1 && d.rs1 == e_exp.rd) || (uses2 && d.rs2 == e_exp.rd));
    endfunction

    // Called just after a negedge with D inputs already driven; returns at the next negedge
    task automatic step(input string tag);
        logic stall;
        #1;
        stall = model_stall();
        chk({tag, "_stallF"},  192'(stall_f),  192'(stall));
        chk({tag, "_stallD"},  192'(stall_d),  192'(stall));
        chk({tag, "_stallF2"}, 192'(stall_f2), 192'(stall));
        @(posedge clk);
        if (flush || stall) begin
            cnt_exp  = (cnt_exp  < 65535) ? cnt_exp + 1  : cnt_exp;
            cnt2_exp = (cnt2_exp < 3)     ? cnt2_exp + 1 : cnt2_exp;
        end
        if (flush || stall || !d.valid) e_exp = '0;
        else begin
            e_exp       = d;
            e_exp.valid = 1'b1;
        end
        #1;
        chk({tag, "_E"},    192'(e_obs),    192'(e_exp));
        chk({tag, "_E2"},   192'(e_obs2),   192'(e_exp));
        chk({tag, "_cnt"},  192'(cnt_obs),  192'(cnt_exp));
        chk({tag, "_cnt2"}, 192'(cnt2_obs), 192'(cnt2_exp));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        d = '0; uses1 = 1'b0; uses2 = 1'b0; flush = 1'b0;
        e_exp = '0; cnt_exp = 0; cnt2_exp = 0;
        repeat (2) @(negedge clk);
        chk("rst_E",   192'(e_obs),   192'(0));
        chk("rst_cnt", 192'(cnt_obs), 192'(0));
        reset = 1'b0;
    endtask

    function automatic stage_t rand_d();
        stage_t r;
        r           = stage_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        r.valid     = ($urandom_range(0, 99) < 85);
        r.rd        = 5'($urandom_range(0, 7));
        r.rs1       = ($urandom_range(0, 1) == 1) ? e_exp.rd : 5'($urandom_range(0, 7));
        r.rs2       = ($urandom_range(0, 2) == 0) ? e_exp.rd : 5'($urandom_range(0, 7));
        r.resultsrc = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom);
        return r;
    endfunction

    function automatic stage_t load_to(input logic [4:0] rd);
        stage_t r;
        r = '0;
        r.valid = 1'b1; r.regwrite = 1'b1; r.resultsrc = 2'b01; r.rd = rd;
        r.pc = 32'h100; r.pcp4 = 32'h104; r.imm = 32'h8;
        return r;
    endfunction

    function automatic stage_t add_op(input logic [4:0] rs1, input logic [4:0] rs2);
        stage_t r;
        r = '0;
        r.valid = 1'b1; r.regwrite = 1'b1; r.aluctl = 3'b000;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = 5'd6; r.rd1 = 32'h11; r.rd2 = 32'h22;
        r.pc = 32'h104; r.pcp4 = 32'h108;
        return r;
    endfunction

    logic [1:0] sat_seq [5];

    initial begin
        reset = 1'b1;
        d = '0; uses1 = 1'b0; uses2 = 1'b0; flush = 1'b0;
        @(negedge clk);
        do_reset();

        // Idle pipeline: nothing captured, nothing counted
        repeat (3) step("idle");
        chk("idle_stallF", 192'(stall_f), 192'(0));

        d = '0; d.valid = 1'b1; d.regwrite = 1'b1; d.aluctl = 3'b010;
        d.rd1 = 32'h5; d.rd2 = 32'h7; d.rd = 5'd3;
        step("pass");
        chk("pass_validE", 192'(e_obs.valid),    192'(1));
        chk("pass_regwr",  192'(e_obs.regwrite), 192'(1));
        chk("pass_rd1",    192'(e_obs.rd1),      192'(32'h5));
        chk("pass_rd2",    192'(e_obs.rd2),      192'(32'h7));
        chk("pass_rdE",    192'(e_obs.rd),       192'(3));

        d = load_to(5'd5);
        step("lu_load");
        d = add_op(5'd5, 5'd0); uses1 = 1'b1;
        #1;
        chk("lu_stallF", 192'(stall_f), 192'(1));
        chk("lu_stallD", 192'(stall_d), 192'(1));
        step("lu_bubble");
        chk("lu_validE", 192'(e_obs.valid),    192'(0));
        chk("lu_regwrE", 192'(e_obs.regwrite), 192'(0));
        chk("lu_cnt",    192'(cnt_obs),        192'(1));
        step("lu_capture");
        chk("lu_cap_validE", 192'(e_obs.valid), 192'(1));

        d = load_to(5'd0); uses1 = 1'b0;
        step("x0_load");
        d = add_op(5'd0, 5'd0); uses1 = 1'b1;
        #1;
        chk("x0_stallF", 192'(stall_f), 192'(0));
        step("x0_use");
        chk("x0_validE", 192'(e_obs.valid), 192'(1));
        chk("x0_cnt",    192'(cnt_obs),     192'(1));

        d = load_to(5'd5); uses1 = 1'b0;
        step("fl_load");
        d = add_op(5'd1, 5'd5); uses2 = 1'b1; flush = 1'b1;
        #1;
        chk("fl_stallF", 192'(stall_f), 192'(1));
        step("fl_bubble");
        chk("fl_validE", 192'(e_obs.valid), 192'(0));
        chk("fl_cnt",    192'(cnt_obs),     192'(2));
        flush = 1'b0;
        step("fl_capture");

        // Narrow counter saturates at 3 without wrapping
        do_reset();
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        d = add_op(5'd1, 5'd2); flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("sat");
            chk("sat_seq", 192'(cnt2_obs), 192'(sat_seq[i]));
        end
        flush = 1'b0;

        // Asynchronous reset while a load-use stall is pending
        d = load_to(5'd4); uses1 = 1'b0; uses2 = 1'b0;
        step("ar_load");
        d = add_op(5'd4, 5'd0); uses1 = 1'b1;
        #1;
        chk("ar_pre_stallF", 192'(stall_f), 192'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("ar_E",      192'(e_obs),   192'(0));
        chk("ar_stallF", 192'(stall_f), 192'(0));
        chk("ar_cnt",    192'(cnt_obs), 192'(0));
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            d     = rand_d();
            uses1 = 1'($urandom);
            uses2 = 1'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the 5-stage RISC-V core.
- Consumes main-decoder and ALU-decoder control outputs, register-file read data, the extended immediate and PC values.
- Registers them into the EX stage.
- Detects load-use hazards, inserts bubbles on load-use or an external flush, and keeps a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width of the register data, PC and immediate fields.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- ValidD  in  1  D-stage holds a real instruction.
- RegWriteD  in  1  decoder control.
- ResultSrcD  in  2  decoder control; 01 = load.
- MemWriteD  in  1  decoder control.
- BranchD  in  1  decoder control.
- JumpD  in  1  decoder control.
- ALUSrcAD  in  1  decoder control.
- ALUSrcBD  in  1  decoder control.
- ALUControlD  in  3  ALU operation select.
- Funct3D  in  3  branch condition select.
- UsesRs1D  in  1  instruction reads rs1.
- UsesRs2D  in  1  instruction reads rs2.
- Rs1D, Rs2D, RdD  in  5 each  register specifiers.
- RD1D, RD2D  in  XLEN each  register-file read data.
- ImmExtD  in  XLEN  extended immediate.
- PCD  in  XLEN  instruction PC.
- PCPlus4D  in  XLEN  PC + 4.
- FlushE  in  1  branch/jump taken in EX; squash the instruction entering EX.
- ValidE  out  1  EX holds a real instruction.
- RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E  out  same widths as D  registered controls.
- Rs1E, Rs2E, RdE  out  5 each  registered specifiers.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each  registered data.
- StallF  out  1  hold PC (combinational).
- StallD  out  1  hold IF/ID register (combinational).
- BubbleCount  out  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset (async, immediate): every E output = 0 and BubbleCount = 0.
  - The all-zero control word is a legal NOP: no RegWrite, no MemWrite, no Branch, no Jump.
- lwStall is combinational and equals the AND of:
  - ValidE
  - ResultSrcE == 2'b01
  - RdE != 0
  - ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE))
- StallF = StallD = lwStall.
  - Comparisons on x0 never stall.
  - Unused source fields never stall.
- bubble = FlushE | lwStall | ~ValidD.
- Each rising clk, priority reset > bubble > capture:
  - bubble: every E register loads 0, including ValidE = 0 and all data fields; the D-side values are discarded.
  - otherwise: every E register loads its D counterpart and ValidE = 1.
- Latency: exactly 1 cycle from D inputs to E outputs.
  - No internal holding: a stalled D instruction is re-presented by the upstream registers and captured once lwStall drops.
- FlushE and lwStall in the same cycle: a single bubble is inserted and counted once.
  - StallF/StallD still assert, since lwStall is independent of FlushE.
- Load-use stall lasts exactly one cycle.
  - After the bubble, ValidE = 0, so lwStall deasserts and the dependent instruction is captured next edge.
- BubbleCount:
  - increments by 1 on each clock edge where (FlushE | lwStall) is true;
  - ~ValidD alone (pipeline empty) is not counted;
  - saturates at 2^CNT_W - 1 with no wrap.
- Reset asserted mid-stall clears ValidE, which immediately drops lwStall and StallF/StallD.

Test Plan:
- Reset release, ValidD = 0 for 3 cycles:
  - all E outputs stay 0;
  - BubbleCount = 0;
  - StallF = 0.
- Pass-through, ValidD = 1, R-type: RegWriteD = 1, ALUControlD = 3'b010, RD1D = 32'h0000_0005, RD2D = 32'h0000_0007, RdD = 3:
  - next edge: ValidE = 1, RegWriteE = 1, RD1E = 5, RD2E = 7, RdE = 3.
- Load-use:
  - cycle n: capture lw, RdD = 5, ResultSrcD = 01.
  - cycle n+1: present add with Rs1D = 5, UsesRs1D = 1. Required: StallF = StallD = 1 that cycle; next edge ValidE = 0, RegWriteE = 0; BubbleCount = 1.
  - cycle n+2: add captured, ValidE = 1.
- Load to x0 (RdD = 0) followed by a use of Rs1D = 0:
  - StallF stays 0;
  - no bubble.
- FlushE = 1 together with a dependent load-use in the same cycle:
  - one bubble, ValidE = 0;
  - BubbleCount increments by exactly 1.
- CNT_W = 2, force 5 flushes:
  - BubbleCount sequence 1, 2, 3, 3, 3.
- Assert reset asynchronously mid-cycle while ValidE = 1:
  - all E outputs go to 0 before the next edge;
  - StallF drops to 0.
